// File: rtl/load_mem_unit_pkg.sv
// load_mem_unit_pkg: RV32 load funct3 codes, CDB entry type, load fault and extract/extend helpers
package load_mem_unit_pkg;
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam int ROB_IX_WIDTH_DEF = 3;
  typedef struct packed {
    logic [31:0]                 data;
    logic [ROB_IX_WIDTH_DEF-1:0] rob_ix;
    logic                        exc;
  } cdb_entry_t;
  function automatic logic load_exc(input logic [2:0] f3, input logic [1:0] off);
    return ((f3 == F3_LH || f3 == F3_LHU) && off[0]) || (f3 == F3_LW && off != 2'd0) ||
           f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
  endfunction
  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    return f3 == F3_LB  ? {{24{b[7]}}, b} :
           f3 == F3_LH  ? {{16{h[15]}}, h} :
           f3 == F3_LBU ? {24'd0, b} :
           f3 == F3_LHU ? {16'd0, h} : w;
  endfunction
endpackage

// File: rtl/load_mem_unit_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO (clk_in, active-low sync rst_in, clr, push/din, pop/dout/valid, count)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd, wr;
  logic             do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    valid  = count != '0;
    do_pop = pop & valid;
    dout   = mem[rd];
  end
  always_ff @(posedge clk_in) begin
    if (push) mem[wr] <= din;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in || clr) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= inc(wr);
      if (do_pop) rd <= inc(rd);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/load_mem_unit.sv
// load_mem_unit: fixed-latency load memory stage (request in, mem_* read port, credit-limited result FIFO onto CDB)
module load_mem_unit
  import load_mem_unit_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2,
  parameter int ROB_IX_WIDTH = 3,
  parameter int OUT_DEPTH    = 4,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    flush_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [ADDR_WIDTH-1:0]   addr_in,
  input  logic [ROB_IX_WIDTH-1:0] rob_ix_in,
  input  logic [2:0]              funct3_in,
  output logic                    mem_en_out,
  output logic [AW-1:0]           mem_addr_out,
  input  logic [31:0]             mem_rdata_in,
  output logic                    cdb_valid_out,
  input  logic                    cdb_ready_in,
  output logic [31:0]             cdb_data_out,
  output logic [ROB_IX_WIDTH-1:0] cdb_rob_ix_out,
  output logic                    cdb_exc_out
);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int EW = 33 + ROB_IX_WIDTH;
  typedef struct packed {
    logic                    v;
    logic [ROB_IX_WIDTH-1:0] rob_ix;
    logic [2:0]              funct3;
    logic [1:0]              off;
    logic                    exc;
  } tag_t;
  tag_t [READ_LATENCY-1:0] tags;
  tag_t                    last;
  logic [CW-1:0]           fifo_count;
  logic [CW:0]             inflight;
  logic [EW-1:0]           fifo_din, fifo_dout;
  logic                    exc_in, accept, push, pop, fifo_valid, unused_addr;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + (CW+1)'(tags[i].v);
  end
  always_comb begin
    unused_addr    = ^addr_in[ADDR_WIDTH-1:AW+2];
    ready_out      = rst_in && ((CW+1)'(fifo_count) + inflight < (CW+1)'(OUT_DEPTH));
    exc_in         = load_exc(funct3_in, addr_in[1:0]);
    accept         = valid_in & ready_out & ~flush_in;
    mem_en_out     = accept & ~exc_in;
    mem_addr_out   = addr_in[AW+1:2];
    last           = tags[READ_LATENCY-1];
    push           = last.v & ~flush_in;
    fifo_din       = {last.exc ? 32'd0 : load_format(last.funct3, last.off, mem_rdata_in), last.rob_ix, last.exc};
    cdb_valid_out  = rst_in & fifo_valid;
    pop            = cdb_valid_out & cdb_ready_in;
    cdb_data_out   = rst_in ? fifo_dout[EW-1 -: 32] : 32'd0;
    cdb_rob_ix_out = rst_in ? fifo_dout[ROB_IX_WIDTH:1] : '0;
    cdb_exc_out    = rst_in & fifo_dout[0];
  end
  always_ff @(posedge clk_in) begin
    tags[0] <= '{v: accept, rob_ix: rob_ix_in, funct3: funct3_in, off: addr_in[1:0], exc: exc_in};
    for (int i = 1; i < READ_LATENCY; i++) tags[i] <= tags[i-1];
    if (!rst_in || flush_in)
      for (int i = 0; i < READ_LATENCY; i++) tags[i].v <= 1'b0;
  end
  sync_fifo #(.WIDTH(EW), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (flush_in),
    .push   (push),
    .pop    (pop),
    .din    (fifo_din),
    .dout   (fifo_dout),
    .valid  (fifo_valid),
    .count  (fifo_count)
  );
endmodule

// File: tb/tb_load_mem_unit.sv
// tb_load_mem_unit: directed self-checking bench for load_mem_unit with a 2-cycle memory model
module tb_load_mem_unit;
  import load_mem_unit_pkg::*;
  logic        clk_in = 0, rst_in = 0, flush_in = 0, valid_in = 0, cdb_ready_in = 1;
  logic        ready_out, mem_en_out, cdb_valid_out, cdb_exc_out;
  logic [31:0] addr_in = 0, mem_rdata_in, cdb_data_out;
  logic [2:0]  rob_ix_in = 0, funct3_in = 0, cdb_rob_ix_out;
  logic [11:0] mem_addr_out;
  logic [31:0] mem [0:4095];
  logic [31:0] r1, r2;
  int          errs = 0, checks = 0, cyc = 0;
  typedef struct {cdb_entry_t e; int c;} res_t;
  res_t q[$];
  load_mem_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .valid_in(valid_in), .ready_out(ready_out),
    .addr_in(addr_in), .rob_ix_in(rob_ix_in), .funct3_in(funct3_in), .mem_en_out(mem_en_out),
    .mem_addr_out(mem_addr_out), .mem_rdata_in(mem_rdata_in), .cdb_valid_out(cdb_valid_out),
    .cdb_ready_in(cdb_ready_in), .cdb_data_out(cdb_data_out), .cdb_rob_ix_out(cdb_rob_ix_out),
    .cdb_exc_out(cdb_exc_out)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    r1  <= mem_en_out ? mem[mem_addr_out] : 32'hDEAD_BEEF;
    r2  <= r1;
  end
  assign mem_rdata_in = r2;
  always @(negedge clk_in)
    if (cdb_valid_out && cdb_ready_in)
      q.push_back('{e: '{data: cdb_data_out, rob_ix: cdb_rob_ix_out, exc: cdb_exc_out}, c: cyc});
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic drive(input logic [31:0] a, input logic [2:0] f, input logic [2:0] r);
    valid_in = 1; addr_in = a; funct3_in = f; rob_ix_in = r;
  endtask
  task automatic wait_res(input int n);
    int t = 0;
    while (q.size() < n && t < 30) begin tick(); t++; end
  endtask
  task automatic test_reset();
    valid_in = 1;
    #2;
    checks++; if (ready_out !== 1'b0) begin errs++; $display("FAIL rst_ready: got %b want 0", ready_out); end
    checks++; if (mem_en_out !== 1'b0) begin errs++; $display("FAIL rst_mem_en: got %b want 0", mem_en_out); end
    checks++; if (cdb_valid_out !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", cdb_valid_out); end
    checks++; if (cdb_data_out !== 32'd0) begin errs++; $display("FAIL rst_data: got %h want 0", cdb_data_out); end
    checks++; if (cdb_exc_out !== 1'b0) begin errs++; $display("FAIL rst_exc: got %b want 0", cdb_exc_out); end
    valid_in = 0;
    tick(); tick();
    rst_in = 1;
    #1;
    checks++; if (ready_out !== 1'b1) begin errs++; $display("FAIL rel_ready: got %b want 1", ready_out); end
    checks++; if (cdb_valid_out !== 1'b0) begin errs++; $display("FAIL rel_valid: got %b want 0", cdb_valid_out); end
  endtask
  task automatic test_format();
    logic [31:0] va [8] = '{32'h17, 32'h17, 32'h16, 32'h14, 32'h16, 32'h15, 32'h14, 32'h4014};
    logic [2:0]  vf [8] = '{F3_LB, F3_LBU, F3_LHU, F3_LH, F3_LH, F3_LB, F3_LW, F3_LW};
    logic [31:0] ve [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'h0000_7F01,
                            32'hFFFF_80FF, 32'h0000_007F, 32'h80FF_7F01, 32'h80FF_7F01};
    int a;
    cdb_ready_in = 1;
    for (int i = 0; i < 8; i++) begin
      q.delete();
      drive(va[i], vf[i], 3'(i));
      #1;
      checks++; if (mem_en_out !== 1'b1) begin errs++; $display("FAIL fmt_mem_en[%0d]: got %b want 1", i, mem_en_out); end
      checks++; if (mem_addr_out !== 12'd5) begin errs++; $display("FAIL fmt_mem_addr[%0d]: got %h want 005", i, mem_addr_out); end
      tick();
      a = cyc;
      valid_in = 0;
      wait_res(1);
      checks++; if (q.size() !== 1) begin errs++; $display("FAIL fmt_count[%0d]: got %0d want 1", i, q.size()); end
      if (q.size() == 1) begin
        checks++; if (q[0].e.data !== ve[i]) begin errs++; $display("FAIL fmt_data[%0d]: got %h want %h", i, q[0].e.data, ve[i]); end
        checks++; if (q[0].e.rob_ix !== 3'(i)) begin errs++; $display("FAIL fmt_rob[%0d]: got %0d want %0d", i, q[0].e.rob_ix, i); end
        checks++; if (q[0].e.exc !== 1'b0) begin errs++; $display("FAIL fmt_exc[%0d]: got %b want 0", i, q[0].e.exc); end
        checks++; if (q[0].c - a !== 2) begin errs++; $display("FAIL fmt_latency[%0d]: got %0d want 2", i, q[0].c - a); end
      end
    end
  endtask
  task automatic test_exceptions();
    logic [31:0] va [5] = '{32'h13, 32'h15, 32'h16, 32'h14, 32'h14};
    logic [2:0]  vf [5] = '{F3_LW, F3_LHU, F3_LW, 3'd3, 3'd7};
    logic [2:0]  vr [5] = '{3'd6, 3'd2, 3'd3, 3'd4, 3'd1};
    int a;
    for (int i = 0; i < 5; i++) begin
      q.delete();
      drive(va[i], vf[i], vr[i]);
      #1;
      checks++; if (mem_en_out !== 1'b0) begin errs++; $display("FAIL exc_mem_en[%0d]: got %b want 0", i, mem_en_out); end
      tick();
      a = cyc;
      valid_in = 0;
      wait_res(1);
      checks++; if (q.size() !== 1) begin errs++; $display("FAIL exc_count[%0d]: got %0d want 1", i, q.size()); end
      if (q.size() == 1) begin
        checks++; if (q[0].e.exc !== 1'b1) begin errs++; $display("FAIL exc_flag[%0d]: got %b want 1", i, q[0].e.exc); end
        checks++; if (q[0].e.data !== 32'd0) begin errs++; $display("FAIL exc_data[%0d]: got %h want 0", i, q[0].e.data); end
        checks++; if (q[0].e.rob_ix !== vr[i]) begin errs++; $display("FAIL exc_rob[%0d]: got %0d want %0d", i, q[0].e.rob_ix, vr[i]); end
        checks++; if (q[0].c - a !== 2) begin errs++; $display("FAIL exc_latency[%0d]: got %0d want 2", i, q[0].c - a); end
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [2:0]  er [3] = '{3'd1, 3'd6, 3'd2};
    logic [31:0] ed [3] = '{32'h0000_0080, 32'd0, 32'h0000_80FF};
    logic        ee [3] = '{1'b0, 1'b1, 1'b0};
    q.delete();
    drive(32'h17, F3_LBU, 3'd1); tick();
    drive(32'h13, F3_LW, 3'd6); tick();
    drive(32'h16, F3_LHU, 3'd2); tick();
    valid_in = 0;
    wait_res(3);
    tick();
    checks++; if (q.size() !== 3) begin errs++; $display("FAIL b2b_count: got %0d want 3", q.size()); end
    if (q.size() == 3)
      for (int i = 0; i < 3; i++) begin
        checks++; if (q[i].e.rob_ix !== er[i]) begin errs++; $display("FAIL b2b_rob[%0d]: got %0d want %0d", i, q[i].e.rob_ix, er[i]); end
        checks++; if (q[i].e.data !== ed[i]) begin errs++; $display("FAIL b2b_data[%0d]: got %h want %h", i, q[i].e.data, ed[i]); end
        checks++; if (q[i].e.exc !== ee[i]) begin errs++; $display("FAIL b2b_exc[%0d]: got %b want %b", i, q[i].e.exc, ee[i]); end
        checks++; if (q[i].c - q[0].c !== i) begin errs++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, q[i].c - q[0].c, i); end
      end
  endtask
  task automatic test_backpressure();
    logic [31:0] ed [4] = '{32'h01, 32'h7F, 32'hFF, 32'h80};
    int acc = 0;
    q.delete();
    cdb_ready_in = 0;
    for (int i = 0; i < 6; i++) begin
      drive(32'h14 + 32'(i % 4), F3_LBU, 3'(i));
      #1;
      if (ready_out) acc++;
      tick();
    end
    valid_in = 0;
    repeat (4) tick();
    checks++; if (acc !== 4) begin errs++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    checks++; if (ready_out !== 1'b0) begin errs++; $display("FAIL bp_ready_full: got %b want 0", ready_out); end
    checks++; if (cdb_valid_out !== 1'b1) begin errs++; $display("FAIL bp_valid: got %b want 1", cdb_valid_out); end
    checks++; if (cdb_data_out !== 32'h01) begin errs++; $display("FAIL bp_head_data: got %h want 00000001", cdb_data_out); end
    repeat (3) tick();
    checks++; if (cdb_data_out !== 32'h01) begin errs++; $display("FAIL bp_stable_data: got %h want 00000001", cdb_data_out); end
    checks++; if (cdb_rob_ix_out !== 3'd0) begin errs++; $display("FAIL bp_stable_rob: got %0d want 0", cdb_rob_ix_out); end
    cdb_ready_in = 1;
    wait_res(4);
    tick();
    checks++; if (q.size() !== 4) begin errs++; $display("FAIL bp_count: got %0d want 4", q.size()); end
    if (q.size() == 4)
      for (int i = 0; i < 4; i++) begin
        checks++; if (q[i].e.rob_ix !== 3'(i)) begin errs++; $display("FAIL bp_rob[%0d]: got %0d want %0d", i, q[i].e.rob_ix, i); end
        checks++; if (q[i].e.data !== ed[i]) begin errs++; $display("FAIL bp_data[%0d]: got %h want %h", i, q[i].e.data, ed[i]); end
      end
    checks++; if (ready_out !== 1'b1) begin errs++; $display("FAIL bp_ready_drained: got %b want 1", ready_out); end
  endtask
  task automatic test_flush();
    int seen = 0;
    q.delete();
    cdb_ready_in = 0;
    drive(32'h17, F3_LB, 3'd1); tick();
    drive(32'h16, F3_LH, 3'd2); tick();
    drive(32'h14, F3_LW, 3'd3); tick();
    drive(32'h15, F3_LBU, 3'd4);
    flush_in = 1;
    #1;
    checks++; if (mem_en_out !== 1'b0) begin errs++; $display("FAIL fl_mem_en: got %b want 0", mem_en_out); end
    tick();
    flush_in = 0;
    valid_in = 0;
    checks++; if (ready_out !== 1'b1) begin errs++; $display("FAIL fl_ready: got %b want 1", ready_out); end
    checks++; if (cdb_valid_out !== 1'b0) begin errs++; $display("FAIL fl_valid: got %b want 0", cdb_valid_out); end
    cdb_ready_in = 1;
    repeat (6) begin tick(); if (cdb_valid_out) seen++; end
    checks++; if (seen !== 0) begin errs++; $display("FAIL fl_late_valid: got %0d want 0", seen); end
    checks++; if (q.size() !== 0) begin errs++; $display("FAIL fl_results: got %0d want 0", q.size()); end
  endtask
  task automatic test_reset_mid();
    int seen = 0, a;
    q.delete();
    cdb_ready_in = 0;
    drive(32'h17, F3_LB, 3'd1); tick();
    drive(32'h17, F3_LBU, 3'd2); tick();
    valid_in = 0;
    tick(); tick();
    checks++; if (cdb_valid_out !== 1'b1) begin errs++; $display("FAIL rm_buffered: got %b want 1", cdb_valid_out); end
    rst_in = 0;
    drive(32'h14, F3_LW, 3'd0);
    #1;
    checks++; if (cdb_valid_out !== 1'b0) begin errs++; $display("FAIL rm_valid: got %b want 0", cdb_valid_out); end
    checks++; if (cdb_data_out !== 32'd0) begin errs++; $display("FAIL rm_data: got %h want 0", cdb_data_out); end
    checks++; if (ready_out !== 1'b0) begin errs++; $display("FAIL rm_ready: got %b want 0", ready_out); end
    checks++; if (mem_en_out !== 1'b0) begin errs++; $display("FAIL rm_mem_en: got %b want 0", mem_en_out); end
    tick(); tick();
    valid_in = 0;
    rst_in = 1;
    #1;
    checks++; if (ready_out !== 1'b1) begin errs++; $display("FAIL rm_ready_rel: got %b want 1", ready_out); end
    cdb_ready_in = 1;
    repeat (4) begin tick(); if (cdb_valid_out) seen++; end
    checks++; if (seen !== 0) begin errs++; $display("FAIL rm_stale: got %0d want 0", seen); end
    q.delete();
    drive(32'h17, F3_LB, 3'd5);
    tick();
    a = cyc;
    valid_in = 0;
    wait_res(1);
    repeat (3) tick();
    checks++; if (q.size() !== 1) begin errs++; $display("FAIL rm_count: got %0d want 1", q.size()); end
    if (q.size() == 1) begin
      checks++; if (q[0].e.data !== 32'hFFFF_FF80) begin errs++; $display("FAIL rm_data_new: got %h want ffffff80", q[0].e.data); end
      checks++; if (q[0].e.rob_ix !== 3'd5) begin errs++; $display("FAIL rm_rob_new: got %0d want 5", q[0].e.rob_ix); end
      checks++; if (q[0].c - a !== 2) begin errs++; $display("FAIL rm_latency: got %0d want 2", q[0].c - a); end
    end
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    mem[5] = 32'h80FF_7F01;
    test_reset();
    test_format();
    test_exceptions();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
